// File: rtl/traffic_light_monitor_pkg.sv
// Shared light codes, error bit positions and monitor FSM state type.
package traffic_light_monitor_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_ORANGE = 2'b10;
  localparam logic [1:0] LIGHT_BAD    = 2'b11;

  localparam int ERR_CODE  = 0;
  localparam int ERR_SEQ   = 1;
  localparam int ERR_DWELL = 2;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_RED,
    ST_GREEN,
    ST_ORANGE
  } mon_state_e;

endpackage

// File: rtl/traffic_light_monitor_dwell.sv
// Saturating run-length counter for the sampled light code; restart loads 1.
module light_dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (restart) begin
      count <= CNT_W'(1);
    end else if (count != '1) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive protocol/dwell checker for the traffic-light bus; never drives the light.
// state     | meaning
// ST_SYNC   | not locked; waiting for a RED sample
// ST_RED    | locked, light is RED; GREEN allowed only after a request
// ST_GREEN  | locked, light is GREEN; exactly GREEN_CYCLES samples before ORANGE
// ST_ORANGE | locked, light is ORANGE; exactly ORANGE_CYCLES samples before RED
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
#(
  parameter int GREEN_CYCLES  = 3,
  parameter int ORANGE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic [1:0]       light,
  output logic [2:0]       err,
  output logic             err_sticky,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycles_seen,
  output logic             synced
);

  localparam logic [CNT_W-1:0] GREEN_LIM  = CNT_W'(GREEN_CYCLES);
  localparam logic [CNT_W-1:0] ORANGE_LIM = CNT_W'(ORANGE_CYCLES);

  mon_state_e       state, state_next;
  logic [1:0]       last_light;
  logic             prev_in;
  logic [CNT_W-1:0] dwell;
  logic             restart;
  logic             code_err, seq_err, dwell_err;
  logic [2:0]       err_next;
  logic             done_next;

  // dwell == 0 only right after reset, so the first sample always starts a fresh run
  assign restart = (light != last_light) || (dwell == '0);

  light_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .count   (dwell)
  );

  always_comb begin
    state_next = state;
    code_err   = 1'b0;
    seq_err    = 1'b0;
    dwell_err  = 1'b0;
    done_next  = 1'b0;
    err_next   = '0;
    // dwell still holds the run length up to the previous sample here
    case (state)
      ST_SYNC: begin
        if (light == LIGHT_RED) state_next = ST_RED;
      end
      ST_RED: begin
        if (light == LIGHT_GREEN) begin
          if (prev_in) state_next = ST_GREEN;
          else         seq_err    = 1'b1;
        end else if (light == LIGHT_ORANGE) begin
          seq_err = 1'b1;
        end
      end
      ST_GREEN: begin
        if (light == LIGHT_ORANGE) begin
          if (dwell == GREEN_LIM) state_next = ST_ORANGE;
          else                    dwell_err  = 1'b1;
        end else if (light == LIGHT_RED) begin
          seq_err = 1'b1;
        end else if (light == LIGHT_GREEN && dwell == GREEN_LIM) begin
          dwell_err = 1'b1;
        end
      end
      ST_ORANGE: begin
        if (light == LIGHT_RED) begin
          if (dwell == ORANGE_LIM) begin
            state_next = ST_RED;
            done_next  = 1'b1;
          end else begin
            dwell_err = 1'b1;
          end
        end else if (light == LIGHT_GREEN) begin
          seq_err = 1'b1;
        end else if (light == LIGHT_ORANGE && dwell == ORANGE_LIM) begin
          dwell_err = 1'b1;
        end
      end
      default: state_next = ST_SYNC;
    endcase
    if (light == LIGHT_BAD) code_err = 1'b1;
    if (code_err)       err_next[ERR_CODE]  = 1'b1;
    else if (seq_err)   err_next[ERR_SEQ]   = 1'b1;
    else if (dwell_err) err_next[ERR_DWELL] = 1'b1;
    if (err_next != '0) begin
      state_next = ST_SYNC;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_SYNC;
      last_light  <= LIGHT_RED;
      prev_in     <= 1'b0;
      err         <= '0;
      err_sticky  <= 1'b0;
      cycle_done  <= 1'b0;
      cycles_seen <= '0;
      synced      <= 1'b0;
    end else begin
      state      <= state_next;
      last_light <= light;
      prev_in    <= in;
      err        <= err_next;
      err_sticky <= err_sticky | (err_next != '0);
      cycle_done <= done_next;
      if (done_next && cycles_seen != '1) cycles_seen <= cycles_seen + CNT_W'(1);
      synced     <= (state_next != ST_SYNC);
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed vector table, corner sequences, random vs reference model.
module tb_traffic_light_monitor;

  localparam logic [1:0] R = 2'b00, G = 2'b01, O = 2'b10, B = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_s = 1'b0;
  logic [1:0] light = R;

  logic [2:0] err8, err2;
  logic       sticky8, sticky2, done8, done2, synced8, synced2;
  logic [7:0] cyc8;
  logic [1:0] cyc2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  traffic_light_monitor #(.GREEN_CYCLES(3), .ORANGE_CYCLES(2), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .in(in_s), .light(light),
    .err(err8), .err_sticky(sticky8), .cycle_done(done8),
    .cycles_seen(cyc8), .synced(synced8)
  );

  traffic_light_monitor #(.GREEN_CYCLES(3), .ORANGE_CYCLES(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in(in_s), .light(light),
    .err(err2), .err_sticky(sticky2), .cycle_done(done2),
    .cycles_seen(cyc2), .synced(synced2)
  );

  // reference model: protocol described as "last code, its run length, locked or not"
  bit         m_locked, m_prev_in, m_sticky, m_done;
  logic [1:0] m_last;
  int         m_run, m_c8, m_c2;
  logic [2:0] m_err;

  function automatic int lim(input logic [1:0] c);
    if (c == G) return 3;
    if (c == O) return 2;
    return 0;
  endfunction

  function automatic logic [1:0] succ(input logic [1:0] c);
    if (c == R) return G;
    if (c == G) return O;
    return R;
  endfunction

  task automatic model(input logic [1:0] l, input logic i, input logic r);
    if (r) begin
      m_locked = 0; m_prev_in = 0; m_sticky = 0; m_done = 0;
      m_last = R; m_run = 0; m_c8 = 0; m_c2 = 0; m_err = 0;
      return;
    end
    m_err = 0; m_done = 0;
    if (l == B) m_err = 3'b001;
    else if (!m_locked) begin
      if (l == R) m_locked = 1;
    end
    else if (l == m_last) begin
      if (lim(l) != 0 && m_run == lim(l)) m_err = 3'b100;
    end
    else if (l != succ(m_last)) m_err = 3'b010;
    else if (m_last == R) begin
      if (!m_prev_in) m_err = 3'b010;
    end
    else if (m_run != lim(m_last)) m_err = 3'b100;
    else if (m_last == O) m_done = 1;
    if (m_err != 0) m_locked = 0;
    if (m_done) begin
      if (m_c8 < 255) m_c8++;
      if (m_c2 < 3) m_c2++;
    end
    m_sticky = m_sticky | (m_err != 0);
    m_run = (l == m_last && m_run > 0) ? m_run + 1 : 1;
    m_last = l;
    m_prev_in = i;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [1:0] l, input logic i, input logic r);
    @(negedge clk);
    light = l; in_s = i; reset = r;
    @(posedge clk);
    #1;
    model(l, i, r);
    check("err8", {29'd0, err8}, {29'd0, m_err});
    check("sticky8", {31'd0, sticky8}, {31'd0, m_sticky});
    check("done8", {31'd0, done8}, {31'd0, m_done});
    check("synced8", {31'd0, synced8}, {31'd0, m_locked});
    check("cycles8", {24'd0, cyc8}, m_c8);
    check("err2", {29'd0, err2}, {29'd0, m_err});
    check("cycles2", {30'd0, cyc2}, m_c2);
  endtask

  typedef struct {
    logic [1:0] light;
    logic       in;
    logic [2:0] err;
    logic       synced;
    logic       done;
    logic       sticky;
    logic [7:0] cycles;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(input logic [1:0] l, input logic i, input logic [2:0] e,
                              input logic s, input logic d, input logic st, input logic [7:0] c);
    vec_t v;
    v.light = l; v.in = i; v.err = e; v.synced = s; v.done = d; v.sticky = st; v.cycles = c;
    return v;
  endfunction

  initial begin
    int dones;
    logic [1:0] cur, nxt;

    // legal cycle, green overstay, sequence errors, illegal code in SYNC and ORANGE
    vecs[0]  = mk(R, 0, 3'b000, 1, 0, 0, 0);
    vecs[1]  = mk(R, 0, 3'b000, 1, 0, 0, 0);
    vecs[2]  = mk(R, 0, 3'b000, 1, 0, 0, 0);
    vecs[3]  = mk(R, 1, 3'b000, 1, 0, 0, 0);
    vecs[4]  = mk(G, 0, 3'b000, 1, 0, 0, 0);
    vecs[5]  = mk(G, 0, 3'b000, 1, 0, 0, 0);
    vecs[6]  = mk(G, 0, 3'b000, 1, 0, 0, 0);
    vecs[7]  = mk(O, 0, 3'b000, 1, 0, 0, 0);
    vecs[8]  = mk(O, 0, 3'b000, 1, 0, 0, 0);
    vecs[9]  = mk(R, 1, 3'b000, 1, 1, 0, 1);
    vecs[10] = mk(G, 0, 3'b000, 1, 0, 0, 1);
    vecs[11] = mk(G, 0, 3'b000, 1, 0, 0, 1);
    vecs[12] = mk(G, 0, 3'b000, 1, 0, 0, 1);
    vecs[13] = mk(G, 0, 3'b100, 0, 0, 1, 1);
    vecs[14] = mk(O, 0, 3'b000, 0, 0, 1, 1);
    vecs[15] = mk(R, 0, 3'b000, 1, 0, 1, 1);
    vecs[16] = mk(G, 0, 3'b010, 0, 0, 1, 1);
    vecs[17] = mk(R, 1, 3'b000, 1, 0, 1, 1);
    vecs[18] = mk(G, 0, 3'b000, 1, 0, 1, 1);
    vecs[19] = mk(R, 0, 3'b010, 0, 0, 1, 1);
    vecs[20] = mk(B, 0, 3'b001, 0, 0, 1, 1);
    vecs[21] = mk(R, 1, 3'b000, 1, 0, 1, 1);
    vecs[22] = mk(G, 0, 3'b000, 1, 0, 1, 1);
    vecs[23] = mk(G, 0, 3'b000, 1, 0, 1, 1);
    vecs[24] = mk(G, 0, 3'b000, 1, 0, 1, 1);
    vecs[25] = mk(O, 0, 3'b000, 1, 0, 1, 1);
    vecs[26] = mk(B, 0, 3'b001, 0, 0, 1, 1);
    vecs[27] = mk(R, 0, 3'b000, 1, 0, 1, 1);

    step(R, 0, 1);
    step(R, 0, 1);
    check("reset_err", {29'd0, err8}, 32'd0);
    check("reset_synced", {31'd0, synced8}, 32'd0);
    check("reset_cycles", {24'd0, cyc8}, 32'd0);

    for (int k = 0; k < 28; k++) begin
      step(vecs[k].light, vecs[k].in, 0);
      check($sformatf("vec%0d_err", k), {29'd0, err8}, {29'd0, vecs[k].err});
      check($sformatf("vec%0d_synced", k), {31'd0, synced8}, {31'd0, vecs[k].synced});
      check($sformatf("vec%0d_done", k), {31'd0, done8}, {31'd0, vecs[k].done});
      check($sformatf("vec%0d_sticky", k), {31'd0, sticky8}, {31'd0, vecs[k].sticky});
      check($sformatf("vec%0d_cycles", k), {24'd0, cyc8}, {24'd0, vecs[k].cycles});
    end

    // reset during ORANGE dwell 1 aborts tracking with no flag
    step(R, 0, 1);
    step(R, 1, 0);
    for (int k = 0; k < 3; k++) step(G, 0, 0);
    step(O, 0, 0);
    step(O, 0, 1);
    check("midreset_err", {29'd0, err8}, 32'd0);
    check("midreset_synced", {31'd0, synced8}, 32'd0);
    check("midreset_sticky", {31'd0, sticky8}, 32'd0);
    step(O, 0, 0);
    step(R, 0, 0);
    check("after_reset_err", {29'd0, err8}, 32'd0);
    check("after_reset_done", {31'd0, done8}, 32'd0);
    check("after_reset_cycles", {24'd0, cyc8}, 32'd0);
    check("after_reset_synced", {31'd0, synced8}, 32'd1);

    // five legal cycles: narrow counter saturates, pulses keep coming
    step(R, 0, 1);
    step(R, 1, 0);
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 3; k++) step(G, 0, 0);
      for (int k = 0; k < 2; k++) step(O, 0, 0);
      step(R, 1, 0);
      if (done2) dones++;
    end
    check("sat_done_count", dones, 32'd5);
    check("sat_cycles2", {30'd0, cyc2}, 32'd3);
    check("sat_cycles8", {24'd0, cyc8}, 32'd5);
    check("sat_sticky", {31'd0, sticky2}, 32'd0);

    // random segments, mostly following the legal order with random run lengths
    step(R, 0, 1);
    cur = R;
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 40) == 0) begin
        step(R, 0, 1);
        cur = R;
      end
      nxt = ($urandom_range(0, 9) < 8) ? succ(cur) : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) nxt = B;
      for (int k = 0, n = $urandom_range(1, 4); k < n; k++)
        step(nxt, 1'($urandom_range(0, 1)), 0);
      cur = nxt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
